// File: rtl/mma_pkg.sv
// Shared types for the MMA tile sequencer: tile geometry, element types, FSM states.
// No logic; constants and typedefs only.
// Backpressure: n/a.
package mma_pkg;
    localparam int TILE_M = 8;
    localparam int TILE_N = 4;
    localparam int TILE_K = 16;
    localparam int P      = 8;
    localparam int ACC_W  = 4 * P;

    typedef logic signed [P-1:0]     op_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        LOAD_C,
        ISSUE,
        WAIT,
        DRAIN
    } seq_state_e;
endpackage

// File: rtl/mma_row_drain.sv
// D result register and row-by-row store stream for the DRAIN phase.
// Latency: first row valid the cycle after capture; one row per accepted beat.
// Backpressure: st_ready_i low holds st_valid_o and st_d_o stable indefinitely.
module mma_row_drain
    import mma_pkg::*;
#(
    parameter int M = TILE_M,
    parameter int N = TILE_N
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  capture_i,
    input  acc_t [M-1:0][N-1:0]   d_i,
    output acc_t [N-1:0]          st_d_o,
    output logic                  st_valid_o,
    input  logic                  st_ready_i,
    output logic                  done_o
);
    localparam int MW = (M > 1) ? $clog2(M) : 1;

    acc_t [M-1:0][N-1:0] d_q;
    logic [MW-1:0]       row_q;
    logic                st_fire;

    assign st_fire = st_valid_o && st_ready_i;
    assign done_o  = st_fire && (row_q == MW'(M - 1));
    assign st_d_o  = d_q[row_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d_q        <= '0;
            row_q      <= '0;
            st_valid_o <= 1'b0;
        end else if (capture_i) begin
            d_q        <= d_i;
            row_q      <= '0;
            st_valid_o <= 1'b1;
        end else if (st_fire) begin
            if (done_o) begin
                row_q      <= '0;
                st_valid_o <= 1'b0;
            end else begin
                row_q <= row_q + MW'(1);
            end
        end
    end
endmodule

// File: rtl/mma_tile_sequencer.sv
// Loads A/B/C tiles row-wise, issues one tile to the MMA unit, drains D row-wise (B reuse: MMA_SEQ_B_REUSE_EN).
// Latency: M+K+M load beats, 1 issue cycle, tile latency, M store beats; no bubbles between beats.
// Backpressure: ld_ready_o low outside LOAD states; operand/store valids hold stable until accepted.
module mma_tile_sequencer
    import mma_pkg::*;
#(
    parameter int M = TILE_M,
    parameter int N = TILE_N,
    parameter int K = TILE_K
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ld_valid_i,
    output logic                  ld_ready_o,
    input  op_t  [K-1:0]          ld_a_i,
    input  op_t  [N-1:0]          ld_b_i,
    input  acc_t [N-1:0]          ld_c_i,
    input  logic                  keep_b_i,
    output op_t  [M-1:0][K-1:0]   mma_a_o,
    output op_t  [K-1:0][N-1:0]   mma_b_o,
    output acc_t [M-1:0][N-1:0]   mma_c_o,
    output logic                  mma_valid_o,
    input  logic                  mma_ready_i,
    input  acc_t [M-1:0][N-1:0]   mma_d_i,
    input  logic                  mma_valid_i,
    output logic                  mma_ready_o,
    output acc_t [N-1:0]          st_d_o,
    output logic                  st_valid_o,
    input  logic                  st_ready_i,
    output logic                  busy_o
);
    localparam int CNT_W = $clog2(((M > K) ? M : K) + 1);
    localparam int MW    = (M > 1) ? $clog2(M) : 1;
    localparam int KW    = (K > 1) ? $clog2(K) : 1;

    seq_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    op_t  [M-1:0][K-1:0] a_q;
    op_t  [K-1:0][N-1:0] b_q;
    acc_t [M-1:0][N-1:0] c_q;
    logic                mma_valid_q, mma_ready_q;
    logic                ld_fire, issue_fire, capture, drain_done, skip_b;
    logic                wr_a, wr_b, wr_c;

    assign ld_ready_o  = state_q inside {LOAD_A, LOAD_B, LOAD_C};
    assign ld_fire     = ld_valid_i && ld_ready_o;
    assign issue_fire  = mma_valid_q && mma_ready_i;
    assign capture     = mma_ready_q && mma_valid_i;
    assign mma_valid_o = mma_valid_q;
    assign mma_ready_o = mma_ready_q;
    assign mma_a_o     = a_q;
    assign mma_b_o     = b_q;
    assign mma_c_o     = c_q;
    assign busy_o      = !((state_q == LOAD_A) && (cnt_q == '0));

`ifdef MMA_SEQ_B_REUSE_EN
    logic keep_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            keep_q <= 1'b0;
        end else if (wr_a && (cnt_q == '0)) begin
            keep_q <= keep_b_i;
        end
    end
    // The first beat's own keep_b_i decides when M == 1.
    assign skip_b = (cnt_q == '0) ? keep_b_i : keep_q;
`else
    logic unused_keep_b;
    assign unused_keep_b = keep_b_i;
    assign skip_b        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_a    = 1'b0;
        wr_b    = 1'b0;
        wr_c    = 1'b0;
        case (state_q)
            LOAD_A: if (ld_fire) begin
                wr_a = 1'b1;
                if (cnt_q == CNT_W'(M - 1)) begin
                    cnt_d   = '0;
                    state_d = skip_b ? LOAD_C : LOAD_B;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LOAD_B: if (ld_fire) begin
                wr_b = 1'b1;
                if (cnt_q == CNT_W'(K - 1)) begin
                    cnt_d   = '0;
                    state_d = LOAD_C;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LOAD_C: if (ld_fire) begin
                wr_c = 1'b1;
                if (cnt_q == CNT_W'(M - 1)) begin
                    cnt_d   = '0;
                    state_d = ISSUE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ISSUE:   if (issue_fire) state_d = WAIT;
            WAIT:    if (capture)    state_d = DRAIN;
            DRAIN:   if (drain_done) state_d = LOAD_A;
            default: state_d = LOAD_A;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= LOAD_A;
            cnt_q       <= '0;
            mma_valid_q <= 1'b0;
            mma_ready_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (wr_a) a_q[cnt_q[MW-1:0]] <= ld_a_i;
            if (wr_b) b_q[cnt_q[KW-1:0]] <= ld_b_i;
            if (wr_c) c_q[cnt_q[MW-1:0]] <= ld_c_i;
            // Raise valid on the edge that completes C so ISSUE never idles a cycle.
            if (wr_c && (state_d == ISSUE)) mma_valid_q <= 1'b1;
            else if (issue_fire)            mma_valid_q <= 1'b0;
            if (issue_fire)   mma_ready_q <= 1'b1;
            else if (capture) mma_ready_q <= 1'b0;
        end
    end

    mma_row_drain #(.M(M), .N(N)) u_drain (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .capture_i  (capture),
        .d_i        (mma_d_i),
        .st_d_o     (st_d_o),
        .st_valid_o (st_valid_o),
        .st_ready_i (st_ready_i),
        .done_o     (drain_done)
    );
endmodule

// File: tb/tb_mma_tile_sequencer.sv
// Bench for mma_tile_sequencer: table of uniform tiles plus hand-written corner sequences,
// behavioural MMA tile, store-row scoreboard.
`timescale 1ns/1ps
module tb_mma_tile_sequencer;
    import mma_pkg::*;
    localparam int M = TILE_M;
    localparam int N = TILE_N;
    localparam int K = TILE_K;

    typedef acc_t [N-1:0]          row_t;
    typedef op_t  [M-1:0][K-1:0]   a_arr_t;
    typedef op_t  [K-1:0][N-1:0]   b_arr_t;
    typedef acc_t [M-1:0][N-1:0]   c_arr_t;
    typedef struct { a_arr_t a; b_arr_t b; c_arr_t c; } tile_t;
    typedef struct { int a; int b; int c; bit thr; bit bp; int d; } vec_t;

    logic clk_i, rst_ni;
    logic ld_valid_i, ld_ready_o, keep_b_i;
    op_t  [K-1:0] ld_a_i;
    op_t  [N-1:0] ld_b_i;
    acc_t [N-1:0] ld_c_i;
    a_arr_t mma_a_o;
    b_arr_t mma_b_o;
    c_arr_t mma_c_o;
    logic   mma_valid_o, mma_ready_i, mma_valid_i, mma_ready_o;
    c_arr_t mma_d_i;
    row_t   st_d_o;
    logic   st_valid_o, st_ready_i, busy_o;

    mma_tile_sequencer dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o),
        .ld_a_i(ld_a_i), .ld_b_i(ld_b_i), .ld_c_i(ld_c_i), .keep_b_i(keep_b_i),
        .mma_a_o(mma_a_o), .mma_b_o(mma_b_o), .mma_c_o(mma_c_o),
        .mma_valid_o(mma_valid_o), .mma_ready_i(mma_ready_i),
        .mma_d_i(mma_d_i), .mma_valid_i(mma_valid_i), .mma_ready_o(mma_ready_o),
        .st_d_o(st_d_o), .st_valid_o(st_valid_o), .st_ready_i(st_ready_i),
        .busy_o(busy_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int     n_cmp = 0, n_bad = 0;
    int     hs_count = 0, drained = 0, idle_cnt = 0;
    bit     count_idle = 0;
    row_t   exp_q[$];
    tile_t  tile_q[$];
    b_arr_t last_b = '0;
    vec_t   vec[6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got no event within bound, want one", name);
    endtask

    function automatic c_arr_t tile_calc(input a_arr_t a, input b_arr_t b, input c_arr_t c);
        c_arr_t d;
        longint s;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) begin
                s = $signed(c[i][j]);
                for (int k = 0; k < K; k++) s += $signed(a[i][k]) * $signed(b[k][j]);
                d[i][j] = acc_t'(s);
            end
        return d;
    endfunction

    // Behavioural MMA tile: ready one cycle after valid, result two cycles after accept.
    initial begin
        tile_t  t;
        c_arr_t dd;
        mma_ready_i = 1'b0;
        mma_valid_i = 1'b0;
        mma_d_i     = '0;
        forever begin
            @(negedge clk_i);
            if (rst_ni && mma_valid_o) begin
                @(negedge clk_i);
                mma_ready_i = 1'b1;
                if (tile_q.size() == 0) fail_now("issue_unexpected");
                else begin
                    t = tile_q.pop_front();
                    for (int i = 0; i < M; i++) check("issue_a_row", mma_a_o[i], t.a[i]);
                    for (int k = 0; k < K; k++) check("issue_b_row", mma_b_o[k], t.b[k]);
                    for (int i = 0; i < M; i++) check("issue_c_row", mma_c_o[i], t.c[i]);
                end
                dd = tile_calc(mma_a_o, mma_b_o, mma_c_o);
                @(negedge clk_i);
                mma_ready_i = 1'b0;
                hs_count++;
                @(negedge clk_i);
                mma_d_i     = dd;
                mma_valid_i = 1'b1;
                for (int w = 0; w < 100 && !mma_ready_o; w++) @(negedge clk_i);
                @(negedge clk_i);
                mma_valid_i = 1'b0;
            end
        end
    end

    // Store scoreboard: every valid row must equal the queue head; pop on accept.
    initial begin
        forever begin
            @(negedge clk_i);
            #1;
            if (rst_ni && st_valid_o) begin
                if (exp_q.size() == 0) fail_now("st_row_unexpected");
                else begin
                    check("st_row", st_d_o, exp_q[0]);
                    check("ld_ready_in_drain", ld_ready_o, 1'b0);
                    if (st_ready_i) begin
                        void'(exp_q.pop_front());
                        drained++;
                    end
                end
            end
            if (count_idle && !busy_o) idle_cnt++;
        end
    end

    task automatic send_beat(input op_t [K-1:0] a, input op_t [N-1:0] b, input acc_t [N-1:0] c,
                             input bit keep);
        int w = 0;
        ld_a_i = a; ld_b_i = b; ld_c_i = c; keep_b_i = keep; ld_valid_i = 1'b1;
        while (!ld_ready_o && w < 500) begin
            @(negedge clk_i);
            w++;
        end
        if (!ld_ready_o) fail_now("ld_accept");
        @(negedge clk_i);
        ld_valid_i = 1'b0;
    endtask

    task automatic push_rows_uniform(input int v);
        row_t r;
        for (int j = 0; j < N; j++) r[j] = acc_t'(v);
        for (int i = 0; i < M; i++) exp_q.push_back(r);
    endtask

    task automatic load_tile(input a_arr_t a, input b_arr_t b, input c_arr_t c,
                             input bit keep, input bit skip_b, input bit thr);
        tile_t t;
        int    total = skip_b ? 2 * M : 2 * M + K;
        int    idx   = 0;
        if (!skip_b) last_b = b;
        t.a = a; t.b = last_b; t.c = c;
        tile_q.push_back(t);
        for (int r = 0; r < M; r++) begin
            send_beat(a[r], '0, '0, keep);
            check("mma_valid_after_beat", mma_valid_o, idx == total - 1); idx++;
            if (thr) @(negedge clk_i);
        end
        if (!skip_b)
            for (int r = 0; r < K; r++) begin
                send_beat('0, b[r], '0, keep);
                check("mma_valid_after_beat", mma_valid_o, idx == total - 1); idx++;
                if (thr) @(negedge clk_i);
            end
        for (int r = 0; r < M; r++) begin
            send_beat('0, '0, c[r], keep);
            check("mma_valid_after_beat", mma_valid_o, idx == total - 1); idx++;
            if (thr) @(negedge clk_i);
        end
    endtask

    task automatic wait_drain(input bit bp);
        int w = 0;
        int d0 = drained;
        if (bp) begin
            while (drained < d0 + 3 && w < 300) begin
                @(negedge clk_i);
                w++;
            end
            st_ready_i = 1'b0;
            repeat (10) @(negedge clk_i);
            st_ready_i = 1'b1;
        end
        while ((exp_q.size() != 0 || busy_o) && w < 1000) begin
            @(negedge clk_i);
            w++;
        end
        if (w >= 1000 || exp_q.size() != 0) fail_now("drain_complete");
    endtask

    task automatic make_uniform(input int av, input int bv, input int cv,
                                output a_arr_t a, output b_arr_t b, output c_arr_t c);
        for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) a[i][k] = op_t'(av);
        for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) b[k][j] = op_t'(bv);
        for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) c[i][j] = acc_t'(cv);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        ld_valid_i = 1'b0;
        st_ready_i = 1'b1;
        @(negedge clk_i);
        exp_q.delete();
        tile_q.delete();
        last_b = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ld_ready"}, ld_ready_o, 1'b1);
        check({tag, "_busy"}, busy_o, 1'b0);
        check({tag, "_mma_valid"}, mma_valid_o, 1'b0);
        check({tag, "_mma_ready"}, mma_ready_o, 1'b0);
        check({tag, "_st_valid"}, st_valid_o, 1'b0);
        check({tag, "_st_d"}, st_d_o, '0);
        for (int i = 0; i < M; i++) check({tag, "_a_row"}, mma_a_o[i], '0);
        for (int k = 0; k < K; k++) check({tag, "_b_row"}, mma_b_o[k], '0);
        for (int i = 0; i < M; i++) check({tag, "_c_row"}, mma_c_o[i], '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        a_arr_t a;
        b_arr_t b;
        c_arr_t c;
        row_t   r;
        int     hs0, d0;

        vec[0] = '{1, 2, 3, 1'b0, 1'b0, 35};
        vec[1] = '{1, 2, 3, 1'b1, 1'b0, 35};
        vec[2] = '{-1, 2, 0, 1'b0, 1'b1, -32};
        vec[3] = '{127, 127, 0, 1'b0, 1'b0, 258064};
        vec[4] = '{-128, -128, 5, 1'b1, 1'b1, 262149};
        vec[5] = '{-128, 127, -7, 1'b0, 1'b0, -260103};

        rst_ni = 1'b0; ld_valid_i = 1'b0; keep_b_i = 1'b0; st_ready_i = 1'b1;
        ld_a_i = '0; ld_b_i = '0; ld_c_i = '0;
        repeat (3) @(negedge clk_i);
        check_reset_outputs("reset");
        rst_ni = 1'b1;
        @(negedge clk_i);

        for (int v = 0; v < 6; v++) begin
            make_uniform(vec[v].a, vec[v].b, vec[v].c, a, b, c);
            push_rows_uniform(vec[v].d);
            hs0 = hs_count; d0 = drained;
            load_tile(a, b, c, 1'b0, 1'b0, vec[v].thr);
            wait_drain(vec[v].bp);
            check("tile_handshakes", hs_count - hs0, 1);
            check("tile_rows_drained", drained - d0, M);
        end

        // Reset after 5 B beats, then an identity tile: D[i][j] = i.
        make_uniform(5, 7, 0, a, b, c);
        for (int r0 = 0; r0 < M; r0++) send_beat(a[r0], '0, '0, 1'b0);
        for (int r0 = 0; r0 < 5; r0++) send_beat('0, b[r0], '0, 1'b0);
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        last_b = '0;
        @(negedge clk_i);
        for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) a[i][k] = op_t'(i == k);
        for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) b[k][j] = op_t'(k);
        c = '0;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) r[j] = acc_t'(i);
            exp_q.push_back(r);
        end
        hs0 = hs_count;
        load_tile(a, b, c, 1'b0, 1'b0, 1'b0);
        wait_drain(1'b0);
        check("identity_handshakes", hs_count - hs0, 1);

`ifdef MMA_SEQ_B_REUSE_EN
        make_uniform(1, 2, 0, a, b, c);
        push_rows_uniform(32);
        load_tile(a, b, c, 1'b0, 1'b0, 1'b0);
        wait_drain(1'b0);
        make_uniform(3, 9, 1, a, b, c);
        push_rows_uniform(97);
        hs0 = hs_count;
        load_tile(a, b, c, 1'b1, 1'b1, 1'b0);
        wait_drain(1'b0);
        check("reuse_handshakes", hs_count - hs0, 1);
`else
        make_uniform(3, 9, 1, a, b, c);
        for (int r0 = 0; r0 < M; r0++) send_beat(a[r0], '0, '0, 1'b1);
        for (int r0 = 0; r0 < M; r0++) send_beat('0, '0, c[r0], 1'b1);
        repeat (5) @(negedge clk_i);
        check("noreuse_still_loading", ld_ready_o, 1'b1);
        check("noreuse_busy", busy_o, 1'b1);
        check("noreuse_no_issue", mma_valid_o, 1'b0);
        do_reset();
`endif

        // Back-to-back tiles: exactly one idle LOAD_A cycle between them.
        hs0 = hs_count;
        make_uniform(2, 1, 0, a, b, c);
        push_rows_uniform(32);
        load_tile(a, b, c, 1'b0, 1'b0, 1'b0);
        idle_cnt = 0;
        count_idle = 1'b1;
        make_uniform(1, -1, 10, a, b, c);
        push_rows_uniform(-6);
        load_tile(a, b, c, 1'b0, 1'b0, 1'b0);
        count_idle = 1'b0;
        check("b2b_idle_cycles", idle_cnt, 1);
        wait_drain(1'b0);
        check("b2b_handshakes", hs_count - hs0, 2);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
